// File: rtl/skin_mask_pkg.sv
// Shared types and constants for the skin mask stream: state encoding,
// fixed-point colour coefficients, default skin box and pipeline latency.
package skin_mask_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Coefficients carry 8 fractional bits.
  localparam int COEF_FRAC = 8;
  localparam int CB_R_COEF = -43;
  localparam int CB_G_COEF = -85;
  localparam int CB_B_COEF = 128;
  localparam int CR_R_COEF = 128;
  localparam int CR_G_COEF = -107;
  localparam int CR_B_COEF = -21;

  localparam int DEF_CB_MIN = 77;
  localparam int DEF_CB_MAX = 127;
  localparam int DEF_CR_MIN = 133;
  localparam int DEF_CR_MAX = 173;

  // Pixel accepted at T produces its mask bit at T+3.
  localparam int PIPE_LATENCY = 3;

endpackage

// File: rtl/skin_mask_stream_rgb_to_cbcr.sv
// Two-stage RGB to CbCr converter: stage 1 forms the six signed products,
// stage 2 sums, floors by the fraction width, recentres and saturates.
// Carries only a valid sideband; no frame awareness.
module rgb_to_cbcr
  import skin_mask_pkg::*;
#(
  parameter int COLOR_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [COLOR_DEPTH-1:0] i_r,
  input  logic [COLOR_DEPTH-1:0] i_g,
  input  logic [COLOR_DEPTH-1:0] i_b,
  output logic                   o_valid,
  output logic [COLOR_DEPTH-1:0] o_cb,
  output logic [COLOR_DEPTH-1:0] o_cr
);

  // Wide enough for a component times a 9-bit signed coefficient, summed three times.
  localparam int PW = COLOR_DEPTH + 10;

  localparam logic signed [PW-1:0] K_CB_R = PW'(CB_R_COEF);
  localparam logic signed [PW-1:0] K_CB_G = PW'(CB_G_COEF);
  localparam logic signed [PW-1:0] K_CB_B = PW'(CB_B_COEF);
  localparam logic signed [PW-1:0] K_CR_R = PW'(CR_R_COEF);
  localparam logic signed [PW-1:0] K_CR_G = PW'(CR_G_COEF);
  localparam logic signed [PW-1:0] K_CR_B = PW'(CR_B_COEF);
  localparam logic signed [PW-1:0] OFFSET = PW'(2 ** (COLOR_DEPTH - 1));
  localparam logic signed [PW-1:0] MAXV   = PW'(2 ** COLOR_DEPTH - 1);

  logic signed [PW-1:0] w_r, w_g, w_b;
  logic signed [PW-1:0] r_cb_r, r_cb_g, r_cb_b;
  logic signed [PW-1:0] r_cr_r, r_cr_g, r_cr_b;
  logic signed [PW-1:0] w_cb_sum, w_cr_sum, w_cb_off, w_cr_off;
  logic                 r_v1;
  logic                 r_v2;
  logic [COLOR_DEPTH-1:0] r_cb, r_cr;

  assign w_r = PW'(i_r);
  assign w_g = PW'(i_g);
  assign w_b = PW'(i_b);

  function automatic logic [COLOR_DEPTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v[PW-1])
      return '0;
    else if (v > MAXV)
      return '1;
    else
      return v[COLOR_DEPTH-1:0];
  endfunction

  assign w_cb_sum = r_cb_r + r_cb_g + r_cb_b;
  assign w_cr_sum = r_cr_r + r_cr_g + r_cr_b;
  assign w_cb_off = (w_cb_sum >>> COEF_FRAC) + OFFSET;
  assign w_cr_off = (w_cr_sum >>> COEF_FRAC) + OFFSET;

  // Valid sideband follows the data through both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= i_valid;
      r_v2 <= r_v1;
    end
  end

  // Datapath registers: products, then saturated Cb/Cr.
  always_ff @(posedge clk) begin
    r_cb_r <= w_r * K_CB_R;
    r_cb_g <= w_g * K_CB_G;
    r_cb_b <= w_b * K_CB_B;
    r_cr_r <= w_r * K_CR_R;
    r_cr_g <= w_g * K_CR_G;
    r_cr_b <= w_b * K_CR_B;
    r_cb   <= sat(w_cb_off);
    r_cr   <= sat(w_cr_off);
  end

  assign o_valid = r_v2;
  assign o_cb    = r_cb;
  assign o_cr    = r_cr;

endmodule

// File: rtl/skin_mask_stream.sv
// Raster RGB stream to 1-bit skin mask for the downstream low-pass filter.
// Always emits exactly WIDTH*DEPTH mask bits per accepted frame, padding
// with zeros if the source underruns, then pulses process_start.
//
// state  | meaning
// IDLE   | waiting for pixel_valid && sof
// STREAM | one pixel expected every cycle
// PAD    | source failed; inject zero bits for remaining positions
// DRAIN  | let the pipeline empty, then fire process_start
module skin_mask_stream
  import skin_mask_pkg::*;
#(
  parameter int WIDTH       = 256,
  parameter int DEPTH       = 256,
  parameter int COLOR_DEPTH = 8,
  parameter int CB_MIN      = DEF_CB_MIN,
  parameter int CB_MAX      = DEF_CB_MAX,
  parameter int CR_MIN      = DEF_CR_MIN,
  parameter int CR_MAX      = DEF_CR_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pixel_valid,
  input  logic                   sof,
  input  logic [COLOR_DEPTH-1:0] r_in,
  input  logic [COLOR_DEPTH-1:0] g_in,
  input  logic [COLOR_DEPTH-1:0] b_in,
  output logic                   mask_enable,
  output logic                   mask_bit,
  output logic                   mask_valid,
  output logic                   process_start,
  output logic                   busy,
  output logic                   frame_error,
  output logic [15:0]            frame_count
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(PIPE_LATENCY + 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(DEPTH - 1);
  localparam logic [COLOR_DEPTH-1:0] CB_LO = COLOR_DEPTH'(CB_MIN);
  localparam logic [COLOR_DEPTH-1:0] CB_HI = COLOR_DEPTH'(CB_MAX);
  localparam logic [COLOR_DEPTH-1:0] CR_LO = COLOR_DEPTH'(CR_MIN);
  localparam logic [COLOR_DEPTH-1:0] CR_HI = COLOR_DEPTH'(CR_MAX);

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [DW-1:0]   r_drain_cnt;
  logic            r_busy, r_frame_error, r_process_start;
  logic [15:0]     r_frame_count;
  logic            r_start_d1, r_pad_d1, r_pad_d2;
  logic            r_mask_enable, r_mask_valid, r_mask_bit;

  logic            w_pos_valid, w_pos_pad, w_pos_start, w_last;
  logic            w_cc_valid, w_skin;
  logic [COLOR_DEPTH-1:0] w_cb, w_cr;

  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

  // Which frame position, if any, occupies the pipeline entry this cycle.
  always_comb begin
    w_pos_valid = 1'b0;
    w_pos_pad   = 1'b0;
    w_pos_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pos_valid = pixel_valid && sof;
        w_pos_start = pixel_valid && sof;
      end
      ST_STREAM: begin
        w_pos_valid = 1'b1;
        w_pos_pad   = !pixel_valid || sof;
      end
      ST_PAD: begin
        w_pos_valid = 1'b1;
        w_pos_pad   = 1'b1;
      end
      default: ;
    endcase
  end

  rgb_to_cbcr #(.COLOR_DEPTH(COLOR_DEPTH)) u_rgb (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_pos_valid),
    .i_r     (r_in),
    .i_g     (g_in),
    .i_b     (b_in),
    .o_valid (w_cc_valid),
    .o_cb    (w_cb),
    .o_cr    (w_cr)
  );

  assign w_skin = (w_cb >= CB_LO) && (w_cb <= CB_HI) &&
                  (w_cr >= CR_LO) && (w_cr <= CR_HI);

  // Frame sequencing, position counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_x             <= '0;
      r_y             <= '0;
      r_drain_cnt     <= '0;
      r_busy          <= 1'b0;
      r_frame_error   <= 1'b0;
      r_process_start <= 1'b0;
      r_frame_count   <= '0;
    end else begin
      r_process_start <= 1'b0;
      if (w_pos_valid) begin
        if (w_last) begin
          r_x <= '0;
          r_y <= '0;
        end else if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (pixel_valid && sof) begin
            r_frame_error <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_pos_pad)
            r_frame_error <= 1'b1;
          if (w_last) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DW'(PIPE_LATENCY);
          end else if (w_pos_pad) begin
            r_state <= ST_PAD;
          end
        end
        ST_PAD: begin
          if (w_last) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DW'(PIPE_LATENCY);
          end
        end
        ST_DRAIN: begin
          if (r_process_start) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_frame_count <= r_frame_count + 1'b1;
          end else if (r_drain_cnt == '0) begin
            r_process_start <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage 3: tag alignment with the colour pipeline and mask thresholding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_d1    <= 1'b0;
      r_pad_d1      <= 1'b0;
      r_pad_d2      <= 1'b0;
      r_mask_enable <= 1'b0;
      r_mask_valid  <= 1'b0;
      r_mask_bit    <= 1'b0;
    end else begin
      r_start_d1    <= w_pos_start;
      r_pad_d1      <= w_pos_pad;
      r_pad_d2      <= r_pad_d1;
      r_mask_enable <= r_start_d1;
      r_mask_valid  <= w_cc_valid;
      r_mask_bit    <= w_cc_valid && !r_pad_d2 && w_skin;
    end
  end

  assign mask_enable   = r_mask_enable;
  assign mask_bit      = r_mask_bit;
  assign mask_valid    = r_mask_valid;
  assign process_start = r_process_start;
  assign busy          = r_busy;
  assign frame_error   = r_frame_error;
  assign frame_count   = r_frame_count;

endmodule
